cp0_irq: RTL

Parametrised coprocessor-0 successor for the multi-cycle MIPS core. It handles synchronous exceptions and level-sensitive external interrupts, and provides a free-running Count/Compare timer. A DEPTH-entry Status/EPC stack supports nested handlers. It sits beside the GPR file and PC: it is read via mfc0, written via mtc0, and drives the redirect address to the PC mux.

---
 rtl/cp0_irq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cp0_irq.sv
// cp0_irq: coprocessor-0 for the multi-cycle MIPS core.
// Synchronous exceptions, level-sensitive interrupts, a Count/Compare timer
// and a ring-buffer Status/EPC stack for nested handlers.
module cp0_irq #(
   parameter int          IRQ_NUM     = 6,
   parameter int          STACK_DEPTH = 4,
   parameter logic [31:0] VECTOR_BASE = 32'h0040_0004
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mtc0,
   input  logic [4:0]         waddr,
   input  logic [31:0]        wdata,
   input  logic [4:0]         raddr,
   input  logic [31:0]        pc,
   input  logic               exception,
   input  logic [4:0]         cause,
   input  logic               eret,
   input  logic [IRQ_NUM-1:0] irq,
   output logic [31:0]        rdata,
   output logic [31:0]        exc_addr,
   output logic               ans_exception,
   output logic               stack_overflow
);

   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   // Cause bits owned by hardware (IP and TI); software writes to them are dropped.
   localparam logic [31:0] IP_MASK = ((32'd1 << IRQ_NUM) - 32'd1) << 8;
   localparam logic [31:0] RO_MASK = IP_MASK | 32'h4000_0000;

   logic [31:0]        regs       [32];
   logic [31:0]        stk_status [STACK_DEPTH];
   logic [31:0]        stk_epc    [STACK_DEPTH];
   logic [PTR_W-1:0]   top;        // next free slot
   logic [CNT_W-1:0]   depth;      // valid entries, saturates at STACK_DEPTH
   logic [IRQ_NUM-1:0] ip;
   logic               ti;

   logic [31:0]        status;
   logic [31:0]        cause_view;
   logic               ie;
   logic               pending;
   logic               take_exc;
   logic               take_irq;
   logic               take;
   logic               do_eret;
   logic [PTR_W-1:0]   ptr_inc;
   logic [PTR_W-1:0]   ptr_dec;

   assign status = regs[REG_STATUS];
   assign ie     = status[0];

   // Action arbitration: mtc0 > exception > pending interrupt > eret.
   always_comb begin
      pending  = ie & ((|(ip & status[8 +: IRQ_NUM])) | (ti & status[15]));
      take_exc = ~mtc0 & exception & ie;
      take_irq = ~mtc0 & ~exception & pending;
      take     = take_exc | take_irq;
      do_eret  = ~mtc0 & ~exception & ~pending & eret;
   end

   // Ring-buffer pointer neighbours, valid for any STACK_DEPTH.
   always_comb begin
      ptr_inc = (top == PTR_W'(STACK_DEPTH - 1)) ? '0 : top + PTR_W'(1);
      ptr_dec = (top == '0) ? PTR_W'(STACK_DEPTH - 1) : top - PTR_W'(1);
   end

   // Cause as software sees it: stored fields plus live IP/TI.
   always_comb begin
      cause_view                = regs[REG_CAUSE] & ~RO_MASK;
      cause_view[8 +: IRQ_NUM]  = ip;
      cause_view[30]            = ti;
   end

   // Combinational register read port.
   always_comb begin
      rdata = regs[raddr];
      if (raddr == REG_CAUSE) rdata = cause_view;
   end

   // Redirect address for the PC mux.
   always_comb begin
      exc_addr = pc;
      if (take)         exc_addr = VECTOR_BASE;
      else if (do_eret) exc_addr = regs[REG_EPC];
   end

   // Register file, timer, interrupt sampling, stack and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         regs[REG_STATUS] <= 32'h1;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stk_status[i] <= '0;
            stk_epc[i]    <= '0;
         end
         top            <= '0;
         depth          <= '0;
         ip             <= '0;
         ti             <= 1'b0;
         ans_exception  <= 1'b0;
         stack_overflow <= 1'b0;
      end else begin
         regs[REG_COUNT] <= regs[REG_COUNT] + 32'd1;
         ip              <= irq;
         if (regs[REG_COUNT] == regs[REG_COMPARE]) ti <= 1'b1;
         ans_exception   <= take;

         if (mtc0) begin
            case (waddr)
               REG_CAUSE:   regs[REG_CAUSE] <= wdata & ~RO_MASK;
               REG_COMPARE: begin
                  regs[REG_COMPARE] <= wdata;
                  ti                <= 1'b0;
               end
               default:     regs[waddr] <= wdata;
            endcase
         end else if (take) begin
            stk_status[top] <= status;
            stk_epc[top]    <= regs[REG_EPC];
            top             <= ptr_inc;
            if (depth == CNT_W'(STACK_DEPTH)) stack_overflow <= 1'b1;
            else                              depth <= depth + CNT_W'(1);
            regs[REG_STATUS][0]   <= 1'b0;
            regs[REG_CAUSE][6:2]  <= take_exc ? cause : 5'd0;
            regs[REG_EPC]         <= pc;
         end else if (do_eret) begin
            if (depth != '0) begin
               regs[REG_STATUS] <= stk_status[ptr_dec];
               regs[REG_EPC]    <= stk_epc[ptr_dec];
               top              <= ptr_dec;
               depth            <= depth - CNT_W'(1);
            end else begin
               regs[REG_STATUS][0] <= 1'b1;
            end
         end
      end
   end

endmodule
